reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised successor to the single-write, dual-read register file.
- Generalised in data width, register count, read-port count and write-port count.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard (pending-write tracking).
- Sits between decode/issue and writeback; issue marks destinations pending, writeback clears them, and readers see a busy flag per port.
- Register 0 is hardwired to zero.

Parameters:
DataWidth, 64, bits per register
NumRegs, 32, number of architectural registers (power of two, >=2)
IndexWidth, $clog2(NumRegs), address width
NumReadPorts, 2, independent combinational read ports
NumWritePorts, 2, independent writeback ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
writeEn  in  NumWritePorts  per-port write strobe
writeAddr  in  NumWritePorts*IndexWidth  packed write addresses, port k at [k*IndexWidth +: IndexWidth]
writeData  in  NumWritePorts*DataWidth  packed write data
readAddr  in  NumReadPorts*IndexWidth  packed read addresses
readData  out  NumReadPorts*DataWidth  packed read data
readBusy  out  NumReadPorts  1 = addressed register has an outstanding producer
issueEn  in  1  mark issueAddr pending
issueAddr  in  IndexWidth  destination being issued
busyVec  out  NumRegs  registered scoreboard, bit i = register i pending
writeConflict  out  1  registered pulse: two enabled write ports hit the same non-zero address last cycle

Behaviour:
- Reset (rst=1 at edge):
  - All registers and busyVec go to 0; writeConflict goes to 0.
  - Writes and issues presented in the reset cycle are discarded.
  - Reset asserted mid-operation has the same effect; there is no partial state.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and issues to address 0 are ignored; they are excluded from conflict detection.
- Writes: register written at the rising edge when writeEn[k]=1 and addr!=0.
- Same-address write collision (same cycle):
  - Highest-indexed port wins.
  - writeConflict=1 for exactly the next cycle.
- Reads: combinational from array, zero added latency.
  - Bypass: if any enabled write port targets readAddr[p] (!=0) this cycle, readData[p] = that port's writeData, highest index winning. Otherwise readData[p] = stored value.
- Scoreboard, next-state per register i!=0:
  - set when issueEn && issueAddr==i;
  - else clear when any enabled write port targets i;
  - else hold.
  - Simultaneous issue and writeback to the same register: set wins (new producer supersedes).
  - Issue to an already-busy register keeps it busy (no counting; a single pending producer per register is architectural).
- readBusy[p] = busyVec[readAddr[p]] && !(write hit on readAddr[p] this cycle). Always 0 for address 0.
- Out-of-range addresses are impossible (NumRegs is a power of two).

Optional Feature:
REGFILE_BYPASS_EN
- Defined: same-cycle write-to-read forwarding and busy masking as above.
- Undefined:
  - readData[p] is always the stored value, so a written value is visible the cycle after the write.
  - readBusy[p] = busyVec[readAddr[p]] with no write-hit masking.
  - Scoreboard and conflict logic are unchanged.

Decomposition:
- Package reg_file_pkg holds:
  - the default constants (DataWidth 64, NumRegs 32);
  - the typedef for the register index;
  - a function returning the winning write-port index for an address (shared by write, bypass and busy-clear logic).
- One natural sub-module, reg_file_scoreboard: busyVec state, set/clear priority, readBusy generation.
- The data array and bypass muxing stay in the top level.

Test Plan:
- Reset with rst=1 for 2 cycles, then read all 32 addresses on both ports -> every readData=0, busyVec=0, writeConflict=0.
- Write 64'hFFFF_FFFF_FFFF_FFFF to regs 1..31 via port 0, then read reg i on port 0 and reg i-1 on port 1 -> port 0 returns all ones for i>=1 and 0 for i=0; port 1 returns all ones for i>=2 and 0 for i=1.
- Same cycle: port0 writes reg5=64'h1111, port1 writes reg5=64'h2222 -> reg5 reads 64'h2222 afterwards; writeConflict=1 for exactly one cycle.
- With REGFILE_BYPASS_EN, write reg7=64'hABCD while readAddr[0]=7 -> readData[0]=64'hABCD in the same cycle. Without the macro -> old value that cycle, 64'hABCD the next cycle.
- Scoreboard sequence:
  - issue reg9 -> busyVec[9]=1 next cycle, readBusy=1 on a port reading 9;
  - write reg9 -> readBusy=0 that cycle (bypass build), busyVec[9]=0 next cycle;
  - issue reg9 and write reg9 in the same cycle -> busyVec[9] stays 1.
- Issue reg12, write reg3=64'h55, then rst=1 for one cycle along with a write to reg4 -> busyVec=0, reg3=0, reg4=0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants, index type and write-port arbitration
// helper for the reg_file_sb register file and its scoreboard.
//
// find_writer() takes write enables and addresses zero-padded to
// MAX_WRITE_PORTS ports of MAX_INDEX_WIDTH bits. It returns the index of the
// highest enabled port that targets the given non-zero address, or -1 when
// no port does. Storage update, read bypass and busy clear all call it, so
// they always pick the same winning port.
package reg_file_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 64;
    localparam int DEFAULT_NUM_REGS    = 32;
    localparam int DEFAULT_INDEX_WIDTH = $clog2(DEFAULT_NUM_REGS);

    // Upper bounds for the padded vectors handed to find_writer().
    localparam int MAX_WRITE_PORTS = 8;
    localparam int MAX_INDEX_WIDTH = 16;

    typedef logic [DEFAULT_INDEX_WIDTH-1:0] reg_idx_t;
    typedef logic [MAX_INDEX_WIDTH-1:0]     wide_idx_t;

    function automatic int find_writer(
        input logic [MAX_WRITE_PORTS-1:0]      en,
        input wide_idx_t [MAX_WRITE_PORTS-1:0] addrs,
        input wide_idx_t                       target
    );
        int winner;
        winner = -1;
        // Ascending scan, so a later (higher) port overrides an earlier one.
        for (int k = 0; k < MAX_WRITE_PORTS; k++) begin
            if (en[k] && (addrs[k] == target) && (target != '0)) begin
                winner = k;
            end
        end
        return winner;
    endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// reg_file_sb_scoreboard: per-register pending-write tracking.
//
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   wr_en_pad   - write strobes, zero-padded to MAX_WRITE_PORTS
//   wr_addr_pad - write addresses, zero-padded to MAX_WRITE_PORTS entries
//   readAddr    - packed read addresses, one per read port
//   issueEn     - mark issueAddr as pending
//   issueAddr   - destination register being issued
//   busyVec     - registered scoreboard, bit i = register i pending
//   readBusy    - per-read-port busy flag
//
// Build option: REGFILE_BYPASS_EN. When it is defined, a writeback that hits
// the register being read masks that port's busy flag in the same cycle.
module reg_file_sb_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NumRegs      = DEFAULT_NUM_REGS,
    parameter int IndexWidth   = $clog2(NumRegs),
    parameter int NumReadPorts = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [MAX_WRITE_PORTS-1:0]          wr_en_pad,
    input  wide_idx_t [MAX_WRITE_PORTS-1:0]     wr_addr_pad,
    input  logic [NumReadPorts*IndexWidth-1:0]  readAddr,
    input  logic                                issueEn,
    input  logic [IndexWidth-1:0]               issueAddr,
    output logic [NumRegs-1:0]                  busyVec,
    output logic [NumReadPorts-1:0]             readBusy
);

    logic [NumRegs-1:0] busy_reg;
    logic [NumRegs-1:0] busy_next;

    // Issue beats writeback: a new producer supersedes the retiring one.
    always_comb begin
        busy_next = busy_reg;
        for (int i = 1; i < NumRegs; i++) begin
            if (issueEn && (issueAddr == IndexWidth'(i))) begin
                busy_next[i] = 1'b1;
            end else if (find_writer(wr_en_pad, wr_addr_pad, wide_idx_t'(i)) >= 0) begin
                busy_next[i] = 1'b0;
            end
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busyVec = busy_reg;

    generate
        for (genvar gi = 0; gi < NumReadPorts; gi++) begin : g_read_busy
            logic [IndexWidth-1:0] rd_addr;
            assign rd_addr = readAddr[gi*IndexWidth +: IndexWidth];
`ifdef REGFILE_BYPASS_EN
            assign readBusy[gi] = busy_reg[rd_addr]
                && (find_writer(wr_en_pad, wr_addr_pad, wide_idx_t'(rd_addr)) < 0);
`else
            assign readBusy[gi] = busy_reg[rd_addr];
`endif
        end
    endgenerate

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with write-to-read bypass and a
// pending-write scoreboard. Register 0 is hardwired to zero.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   writeEn       - per write port strobe
//   writeAddr     - packed write addresses, port k at [k*IndexWidth +: IndexWidth]
//   writeData     - packed write data, port k at [k*DataWidth +: DataWidth]
//   readAddr      - packed read addresses
//   readData      - packed combinational read data
//   readBusy      - per read port: addressed register has a pending producer
//   issueEn       - mark issueAddr as pending
//   issueAddr     - destination being issued
//   busyVec       - registered scoreboard
//   writeConflict - registered pulse: two enabled write ports hit the same
//                   non-zero address in the previous cycle
//
// Build option: REGFILE_BYPASS_EN. When it is defined, readData forwards the
// winning same-cycle writeData; otherwise a write is visible one cycle later.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DataWidth     = DEFAULT_DATA_WIDTH,
    parameter int NumRegs       = DEFAULT_NUM_REGS,
    parameter int IndexWidth    = $clog2(NumRegs),
    parameter int NumReadPorts  = 2,
    parameter int NumWritePorts = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NumWritePorts-1:0]             writeEn,
    input  logic [NumWritePorts*IndexWidth-1:0]  writeAddr,
    input  logic [NumWritePorts*DataWidth-1:0]   writeData,
    input  logic [NumReadPorts*IndexWidth-1:0]   readAddr,
    output logic [NumReadPorts*DataWidth-1:0]    readData,
    output logic [NumReadPorts-1:0]              readBusy,
    input  logic                                 issueEn,
    input  logic [IndexWidth-1:0]                issueAddr,
    output logic [NumRegs-1:0]                   busyVec,
    output logic                                 writeConflict
);

    logic [MAX_WRITE_PORTS-1:0]      wr_en_pad;
    wide_idx_t [MAX_WRITE_PORTS-1:0] wr_addr_pad;
    logic [DataWidth-1:0]            regs_reg [NumRegs];
    int                              wr_sel [NumRegs];
    logic                            conflict_reg;
    logic                            conflict_next;

    // Unused padding ports stay disabled so they can never win.
    always_comb begin
        wr_en_pad   = '0;
        wr_addr_pad = '0;
        for (int k = 0; k < NumWritePorts; k++) begin
            wr_en_pad[k]   = writeEn[k];
            wr_addr_pad[k] = wide_idx_t'(writeAddr[k*IndexWidth +: IndexWidth]);
        end
    end

    // Winning port per register; always -1 for register 0.
    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            wr_sel[i] = find_writer(wr_en_pad, wr_addr_pad, wide_idx_t'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumRegs; i++) begin
                if (wr_sel[i] >= 0) begin
                    regs_reg[i] <= writeData[wr_sel[i]*DataWidth +: DataWidth];
                end
            end
        end
    end

    always_comb begin
        conflict_next = 1'b0;
        for (int j = 0; j < NumWritePorts; j++) begin
            for (int k = j + 1; k < NumWritePorts; k++) begin
                if (writeEn[j] && writeEn[k]
                    && (wr_addr_pad[j] == wr_addr_pad[k])
                    && (wr_addr_pad[j] != '0)) begin
                    conflict_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_reg <= 1'b0;
        end else begin
            conflict_reg <= conflict_next;
        end
    end

    assign writeConflict = conflict_reg;

    // Register 0 is held at zero by reset and never written, so a plain
    // array read already returns 0 for address 0.
    generate
        for (genvar gi = 0; gi < NumReadPorts; gi++) begin : g_read
            logic [IndexWidth-1:0] rd_addr;
            assign rd_addr = readAddr[gi*IndexWidth +: IndexWidth];
`ifdef REGFILE_BYPASS_EN
            int rd_sel;
            assign rd_sel = find_writer(wr_en_pad, wr_addr_pad, wide_idx_t'(rd_addr));
            assign readData[gi*DataWidth +: DataWidth] =
                (rd_sel >= 0) ? writeData[rd_sel*DataWidth +: DataWidth]
                              : regs_reg[rd_addr];
`else
            assign readData[gi*DataWidth +: DataWidth] = regs_reg[rd_addr];
`endif
        end
    endgenerate

    reg_file_sb_scoreboard #(
        .NumRegs      (NumRegs),
        .IndexWidth   (IndexWidth),
        .NumReadPorts (NumReadPorts)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .wr_en_pad   (wr_en_pad),
        .wr_addr_pad (wr_addr_pad),
        .readAddr    (readAddr),
        .issueEn     (issueEn),
        .issueAddr   (issueAddr),
        .busyVec     (busyVec),
        .readBusy    (readBusy)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed, table-driven bench for reg_file_sb at default parameters.
// Expectations that depend on REGFILE_BYPASS_EN follow the same macro.
module tb_reg_file_sb;
    import reg_file_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    writeEn;
    logic [9:0]    writeAddr;
    logic [127:0]  writeData;
    logic [9:0]    readAddr;
    logic [127:0]  readData;
    logic [1:0]    readBusy;
    logic          issueEn;
    logic [4:0]    issueAddr;
    logic [31:0]   busyVec;
    logic          writeConflict;

    int n_checks = 0;
    int n_pass   = 0;

    reg_file_sb dut (
        .clk           (clk),
        .rst           (rst),
        .writeEn       (writeEn),
        .writeAddr     (writeAddr),
        .writeData     (writeData),
        .readAddr      (readAddr),
        .readData      (readData),
        .readBusy      (readBusy),
        .issueEn       (issueEn),
        .issueAddr     (issueAddr),
        .busyVec       (busyVec),
        .writeConflict (writeConflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        reg_idx_t    wa0;
        logic [63:0] wd0;
        reg_idx_t    wa1;
        logic [63:0] wd1;
        reg_idx_t    ra0;
        reg_idx_t    ra1;
        logic        iss;
        reg_idx_t    ia;
        logic [63:0] e_rd0;
        logic [63:0] e_rd1;
        logic        e_bz0;
        logic        e_bz1;
        logic        e_conf;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [1:0] we, input reg_idx_t wa0, input logic [63:0] wd0,
                           input reg_idx_t wa1, input logic [63:0] wd1,
                           input reg_idx_t ra0, input reg_idx_t ra1,
                           input logic iss, input reg_idx_t ia,
                           input logic [63:0] e_rd0, input logic [63:0] e_rd1,
                           input logic e_bz0, input logic e_bz1,
                           input logic e_conf, input logic [31:0] e_busy);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ra0 = ra0; v.ra1 = ra1; v.iss = iss; v.ia = ia;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_bz0 = e_bz0; v.e_bz1 = e_bz1;
        v.e_conf = e_conf; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input reg_idx_t wa0, input logic [63:0] wd0,
                         input reg_idx_t wa1, input logic [63:0] wd1,
                         input reg_idx_t ra0, input reg_idx_t ra1,
                         input logic iss, input reg_idx_t ia);
        writeEn   = we;
        writeAddr = {wa1, wa0};
        writeData = {wd1, wd0};
        readAddr  = {ra1, ra0};
        issueEn   = iss;
        issueAddr = ia;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] B9  = 32'h1 << 9;
    localparam logic [31:0] B12 = 32'h1 << 12;

    initial begin
        // Register state before the table: regs 1..31 all ones, nothing busy.
        add_vec(2'b11, 5, 64'h1111, 5, 64'h2222, 5, 6, 0, 0,
                BYP ? 64'h2222 : ONES, ONES, 0, 0, 1, 0);
        add_vec(2'b00, 0, 0, 0, 0, 5, 0, 0, 0, 64'h2222, 0, 0, 0, 0, 0);
        add_vec(2'b01, 7, 64'hABCD, 0, 0, 7, 5, 0, 0,
                BYP ? 64'hABCD : ONES, 64'h2222, 0, 0, 0, 0);
        add_vec(2'b00, 0, 0, 0, 0, 7, 5, 0, 0, 64'hABCD, 64'h2222, 0, 0, 0, 0);
        add_vec(2'b00, 0, 0, 0, 0, 9, 1, 1, 9, ONES, ONES, 0, 0, 0, B9);
        add_vec(2'b00, 0, 0, 0, 0, 9, 9, 0, 0, ONES, ONES, 1, 1, 0, B9);
        add_vec(2'b10, 0, 0, 9, 64'h99, 9, 8, 0, 0,
                BYP ? 64'h99 : ONES, ONES, !BYP, 0, 0, 0);
        add_vec(2'b01, 9, 64'h77, 0, 0, 9, 9, 1, 9,
                BYP ? 64'h77 : 64'h99, BYP ? 64'h77 : 64'h99, 0, 0, 0, B9);
        add_vec(2'b00, 0, 0, 0, 0, 9, 0, 0, 0, 64'h77, 0, 1, 0, 0, B9);
        add_vec(2'b11, 0, 64'h123, 0, 64'h456, 0, 9, 1, 0, 0, 64'h77, 0, 1, 0, B9);
        add_vec(2'b01, 6, 64'h66, 6, 64'h99, 6, 6, 0, 0,
                BYP ? 64'h66 : ONES, BYP ? 64'h66 : ONES, 0, 0, 0, B9);
        add_vec(2'b11, 10, 64'hA, 11, 64'hB, 10, 11, 0, 0,
                BYP ? 64'hA : ONES, BYP ? 64'hB : ONES, 0, 0, 0, B9);
        add_vec(2'b00, 0, 0, 0, 0, 10, 11, 1, 12, 64'hA, 64'hB, 0, 0, 0, B9 | B12);
        add_vec(2'b00, 0, 0, 0, 0, 12, 6, 1, 12, ONES, 64'h66, 1, 0, 0, B9 | B12);

        // Reset held for two cycles.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        check("reset_busyVec", 64'(busyVec), 0);
        check("reset_conflict", 64'(writeConflict), 0);
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 0, reg_idx_t'(i), reg_idx_t'(31 - i), 0, 0);
            #1;
            check($sformatf("reset_rd0[%0d]", i), readData[63:0], 0);
            check($sformatf("reset_rd1[%0d]", 31 - i), readData[127:64], 0);
        end

        // Fill regs 1..31 with all ones through port 0 (address 0 included
        // to confirm it is ignored).
        for (int i = 0; i < 32; i++) begin
            drive(2'b01, reg_idx_t'(i), ONES, 0, 0, 0, 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 0, reg_idx_t'(i), reg_idx_t'((i == 0) ? 0 : i - 1), 0, 0);
            #1;
            check($sformatf("fill_rd0[%0d]", i), readData[63:0], (i >= 1) ? ONES : 64'h0);
            check($sformatf("fill_rd1[%0d]", i), readData[127:64], (i >= 2) ? ONES : 64'h0);
        end
        tick();

        // Table: inputs applied just after an edge, combinational outputs
        // checked mid-cycle, registered outputs checked after the next edge.
        foreach (vecs[n]) begin
            drive(vecs[n].we, vecs[n].wa0, vecs[n].wd0, vecs[n].wa1, vecs[n].wd1,
                  vecs[n].ra0, vecs[n].ra1, vecs[n].iss, vecs[n].ia);
            #4;
            check($sformatf("v%0d_rd0", n), readData[63:0], vecs[n].e_rd0);
            check($sformatf("v%0d_rd1", n), readData[127:64], vecs[n].e_rd1);
            check($sformatf("v%0d_busy0", n), 64'(readBusy[0]), 64'(vecs[n].e_bz0));
            check($sformatf("v%0d_busy1", n), 64'(readBusy[1]), 64'(vecs[n].e_bz1));
            tick();
            check($sformatf("v%0d_conflict", n), 64'(writeConflict), 64'(vecs[n].e_conf));
            check($sformatf("v%0d_busyVec", n), 64'(busyVec), 64'(vecs[n].e_busy));
            $display("vec %0d: rd0=%h rd1=%h busy=%b conf=%b busyVec=%h",
                     n, vecs[n].e_rd0, vecs[n].e_rd1, {vecs[n].e_bz1, vecs[n].e_bz0},
                     vecs[n].e_conf, vecs[n].e_busy);
        end

        // Mid-operation reset: a conflicting write to reg3 (port 1 = 0x55
        // wins), then reset together with a write to reg4.
        drive(2'b11, 3, 64'h11, 3, 64'h55, 3, 0, 0, 0);
        tick();
        check("pre_reset_conflict", 64'(writeConflict), 1);
        check("pre_reset_busyVec", 64'(busyVec), 64'(B9 | B12));
        drive(0, 0, 0, 0, 0, 3, 0, 0, 0);
        #1;
        check("pre_reset_reg3", readData[63:0], 64'h55);
        rst = 1'b1;
        drive(2'b01, 4, 64'hDEAD, 0, 0, 3, 4, 1, 20);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 3, 4, 0, 0);
        #1;
        check("mid_reset_busyVec", 64'(busyVec), 0);
        check("mid_reset_conflict", 64'(writeConflict), 0);
        check("mid_reset_reg3", readData[63:0], 0);
        check("mid_reset_reg4", readData[127:64], 0);
        $display("mid-op reset: reg3=%h reg4=%h busyVec=%h", readData[63:0], readData[127:64], busyVec);

        // Normal operation resumes after reset.
        drive(2'b01, 4, 64'hDEAD, 0, 0, 12, 4, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 12, 4, 0, 0);
        #1;
        check("post_reset_reg4", readData[127:64], 64'hDEAD);
        check("post_reset_busy12", 64'(readBusy[0]), 0);
        $display("post reset: reg4=%h", readData[127:64]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_checks);
        $fatal(1);
    end

endmodule
